// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU operation sequencer.
//   DATA_W          : operand / result width
//   OP_*            : 4-bit ALU select codes driven on alu_sel
//   seq_state_e     : sequencer FSM states
//   is_div_by_zero  : flags a command that must not be sent to the ALU
package alu_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_MOD = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8;
   localparam logic [3:0] OP_SHL = 4'd9;
   localparam logic [3:0] OP_SHR = 4'd10;
   localparam logic [3:0] OP_ROL = 4'd11;
   localparam logic [3:0] OP_ROR = 4'd12;
   localparam logic [3:0] OP_LT  = 4'd13;
   localparam logic [3:0] OP_GT  = 4'd14;
   localparam logic [3:0] OP_EQ  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } seq_state_e;

   function automatic logic is_div_by_zero(input logic [3:0] op,
                                           input logic [DATA_W-1:0] b);
      return (op == OP_DIV) && (b == {DATA_W{1'b0}});
   endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer -- accepts one ALU command at a time, drives registered
// operands to an external ALU, waits SETTLE_CYCLES and captures the result
// into a response register held until the consumer takes it.
//   clk, rst_n                       : clock, synchronous active-low reset
//   cmd_valid/cmd_ready              : command handshake
//   cmd_op, cmd_a, cmd_b, cmd_chain  : command fields (chain: A = last result)
//   alu_a, alu_b, alu_sel            : registered ALU drive
//   alu_out, alu_carry               : ALU result inputs
//   rsp_valid/rsp_ready              : response handshake
//   rsp_data, rsp_carry, rsp_err     : captured response
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic              cmd_chain,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic              rsp_err
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   seq_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              err_pend_q, err_pend_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [3:0]        alu_sel_q, alu_sel_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_carry_q, rsp_carry_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic [DATA_W-1:0] last_result_q, last_result_d;
   logic [DATA_W-1:0] eff_a_s;

   // Next-state, datapath and output-flag computation for the sequencer FSM.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      err_pend_d    = err_pend_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_sel_d     = alu_sel_q;
      rsp_data_d    = rsp_data_q;
      rsp_carry_d   = rsp_carry_q;
      rsp_err_d     = rsp_err_q;
      last_result_d = last_result_q;
      eff_a_s       = cmd_chain ? last_result_q : cmd_a;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = ST_DRIVE;
               if (is_div_by_zero(cmd_op, cmd_b)) begin
                  // Rejected command: the ALU drive is left untouched and the
                  // error response is produced after a single DRIVE cycle, so
                  // it has the same one-cycle latency as a SETTLE_CYCLES=1 op.
                  err_pend_d = 1'b1;
                  cnt_d      = 4'd0;
               end else begin
                  err_pend_d = 1'b0;
                  cnt_d      = SETTLE_LOAD;
                  alu_a_d    = eff_a_s;
                  alu_b_d    = cmd_b;
                  alu_sel_d  = cmd_op;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               if (err_pend_q) begin
                  rsp_data_d  = 8'hFF;
                  rsp_carry_d = 1'b0;
                  rsp_err_d   = 1'b1;
               end else begin
                  rsp_data_d    = alu_out;
                  rsp_carry_d   = alu_carry;
                  rsp_err_d     = 1'b0;
                  last_result_d = alu_out;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Handshake flags are registered copies of the next state.
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 4'd0;
         err_pend_q    <= 1'b0;
         alu_a_q       <= 8'd0;
         alu_b_q       <= 8'd0;
         alu_sel_q     <= 4'd0;
         rsp_data_q    <= 8'd0;
         rsp_carry_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         cmd_ready_q   <= 1'b1;
         last_result_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         err_pend_q    <= err_pend_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_sel_q     <= alu_sel_d;
         rsp_data_q    <= rsp_data_d;
         rsp_carry_q   <= rsp_carry_d;
         rsp_err_q     <= rsp_err_d;
         rsp_valid_q   <= rsp_valid_d;
         cmd_ready_q   <= cmd_ready_d;
         last_result_q <= last_result_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_err   = rsp_err_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;

endmodule
